fft_peak_detect: RTL and testbench
==================================

Name: fft_peak_detect

Overview:
- Sits directly downstream of the 16-point FFT stage in the FAS datapath.
- Captures one 16-bin spectrum frame when fft_valid pulses.
- Computes the squared magnitude of each bin sequentially, one bin per cycle, and finds the bin with the largest magnitude.
- Reports that bin index on freq, with a one-cycle done pulse.

Parameters:
- DW, 16, width of each real and imaginary component (signed two's complement). Each fft_dN bus is 2*DW bits wide.
- MW, 2*DW, width of the squared-magnitude accumulator (re^2+im^2, unsigned).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- fft_valid  input  1  single-cycle strobe: fft_d0..fft_d15 hold a complete frame.
- fft_d0 .. fft_d15  input  2*DW each  bin k value: [2*DW-1:DW] = real, [DW-1:0] = imaginary, both signed.
- done  output  1  one-cycle pulse: freq has been updated.
- freq  output  4  index (0..15) of the peak-magnitude bin of the last completed frame.
- busy  output  1  high while a frame is being scanned.
- overrun  output  1  one-cycle pulse: a fft_valid was dropped.

Behaviour:
- Reset (async, rst=1):
  - done=0, freq=0, busy=0, overrun=0.
  - FSM goes to IDLE; frame buffer, bin index, max value and max index are cleared.
  - Reset mid-scan abandons the frame; no done is produced for it.
- FSM states: IDLE, SCAN, FLUSH.
  - IDLE: on fft_valid=1, latch all 16 bins into the frame buffer, set idx=0, go to SCAN.
  - SCAN, stage 1: each cycle, select bin idx and register sq = re*re + im*im.
    - Products are signed DW x DW, giving 2*DW-1 bits unsigned.
    - The sum fits in MW bits without overflow; the worst case -2^(DW-1) on both parts is exactly 2^(2*DW-1).
  - SCAN, progression: idx increments 0..15; at idx=15 go to FLUSH.
  - Stage 2 (compare): each cycle after a valid sq, if sq > maxv (strict), then maxv<=sq and maxi<=bin of sq.
    - The first bin of a frame unconditionally loads maxv/maxi.
    - Ties: the lowest index wins.
    - All-zero frame gives freq=0.
  - FLUSH: the last compare completes. Next cycle: freq<=maxi, done=1 for exactly one cycle, then go to IDLE.
    - A frame accepted in the SCAN idx=15 cycle goes from FLUSH to SCAN instead; freq and done are still produced for the old frame.
- Latency: fft_valid sampled at edge E0; done and new freq are visible after edge E0+18.
  - freq holds its value until the next done.
- Back-to-back acceptance: fft_valid is accepted in IDLE, and also in SCAN when idx=15.
  - At idx=15, bin 15 is already selected and squared that edge, so the buffer may be overwritten.
  - Minimum supported frame spacing is therefore 16 cycles, matching one FFT frame per 16 FIR samples.
- Overrun: fft_valid in SCAN with idx<15, or in FLUSH without a pending accept, is dropped.
  - overrun pulses one cycle (the cycle after the edge); the scan in progress is unaffected.
- busy = 1 in SCAN and FLUSH, 0 in IDLE.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then a frame with bin 5 = {re=16'h0400, im=16'h0300} and all others 0 -> done pulses once 18 cycles after fft_valid; freq=5; busy high for 17 cycles; overrun=0.
2. Tie: bin 3 = {16'h0100,16'h0000} and bin 9 = {16'h0000,16'hFF00} (equal magnitude 2^16) -> freq=3. All-zero frame -> freq=0.
3. Sign/extreme values:
   - bin 12 = {16'h8000,16'h8000} (sq=2^31), all others {16'h7FFF,16'h7FFF} -> freq=12, with no overflow wrap.
   - bin 0 = {16'hFF00,0} vs bin 1 = {16'h00FF,0} -> freq=0.
4. Back-to-back frames 16 cycles apart, peaks at bins 2 then 14 -> two done pulses 16 cycles apart; freq=2 then 14; overrun never asserted.
5. Second fft_valid 8 cycles after the first -> overrun pulses one cycle; a single done; freq reflects the first frame only.
6. Assert rst during SCAN (idx=7), release, idle 20 cycles -> no done; freq=0; busy=0; a subsequent frame with peak at bin 10 gives freq=10 at nominal latency.

Source files
------------

// File: rtl/fft_peak_detect.sv
// fft_peak_detect
//   Captures one 16-bin complex spectrum frame from the upstream FFT stage,
//   squares the magnitude of one bin per cycle and reports the index of the
//   strongest bin. Ties resolve to the lowest bin index.
//
// Ports
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   fft_valid         single-cycle strobe, fft_d0..fft_d15 hold a full frame
//   fft_d0..fft_d15   bin k: [2*DW-1:DW] signed real, [DW-1:0] signed imag
//   done              one-cycle pulse, freq has just been updated
//   freq              peak-magnitude bin index of the last completed frame
//   busy              high while a frame is scanned (SCAN or FLUSH)
//   overrun           one-cycle pulse, an fft_valid was dropped
module fft_peak_detect #(
  parameter int DW = 16,
  parameter int MW = 2 * DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Squared magnitude re^2 + im^2. Each product is at most 2^(2*DW-2), so
  // the sum (at most 2^(2*DW-1)) always fits the unsigned MW-bit result.
  function automatic logic [MW-1:0] mag_sq(input logic [2*DW-1:0] bin);
    logic signed [DW-1:0]   re_v;
    logic signed [DW-1:0]   im_v;
    logic signed [2*DW-1:0] p_re;
    logic signed [2*DW-1:0] p_im;
    re_v = bin[2*DW-1:DW];
    im_v = bin[DW-1:0];
    p_re = (2*DW)'(re_v) * (2*DW)'(re_v);
    p_im = (2*DW)'(im_v) * (2*DW)'(im_v);
    return MW'(p_re) + MW'(p_im);
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      idx_r;
  logic [3:0]      idx_s;
  logic            pend_r;     // frame accepted at idx=15, starts from FLUSH
  logic            pend_s;
  logic            accept_s;
  logic            drop_s;
  logic            sq_en_s;

  logic [2*DW-1:0] in_s [16];
  logic [2*DW-1:0] frame_r [16];

  logic [MW-1:0]   sq_r;
  logic            sq_valid_r;
  logic [3:0]      sq_bin_r;
  logic [MW-1:0]   maxv_r;
  logic [3:0]      maxi_r;
  logic            fin_r;      // final compare of a frame completes this cycle

  logic            done_r;
  logic [3:0]      freq_r;
  logic            busy_r;
  logic            overrun_r;

  assign in_s[0]  = fft_d0;
  assign in_s[1]  = fft_d1;
  assign in_s[2]  = fft_d2;
  assign in_s[3]  = fft_d3;
  assign in_s[4]  = fft_d4;
  assign in_s[5]  = fft_d5;
  assign in_s[6]  = fft_d6;
  assign in_s[7]  = fft_d7;
  assign in_s[8]  = fft_d8;
  assign in_s[9]  = fft_d9;
  assign in_s[10] = fft_d10;
  assign in_s[11] = fft_d11;
  assign in_s[12] = fft_d12;
  assign in_s[13] = fft_d13;
  assign in_s[14] = fft_d14;
  assign in_s[15] = fft_d15;

  // Next-state, accept/drop decisions and stage-1 enable.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    pend_s   = pend_r;
    accept_s = 1'b0;
    drop_s   = 1'b0;
    sq_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fft_valid) begin
          accept_s = 1'b1;
          idx_s    = 4'd0;
          state_s  = SCAN;
        end else begin
          state_s  = IDLE;
        end
      end
      SCAN: begin
        sq_en_s = 1'b1;
        if (idx_r == 4'd15) begin
          // Bin 15 is squared on this edge, so the buffer is free to reload.
          idx_s   = 4'd0;
          state_s = FLUSH;
          if (fft_valid) begin
            accept_s = 1'b1;
            pend_s   = 1'b1;
          end else begin
            pend_s   = 1'b0;
          end
        end else begin
          idx_s  = idx_r + 4'd1;
          drop_s = fft_valid;
        end
      end
      FLUSH: begin
        drop_s = fft_valid;
        if (pend_r) begin
          // FLUSH doubles as the idx=0 step of the pending frame.
          sq_en_s = 1'b1;
          idx_s   = idx_r + 4'd1;
          pend_s  = 1'b0;
          state_s = SCAN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
        pend_s  = 1'b0;
      end
    endcase
  end

  // FSM state, bin index and pending-frame flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      pend_r  <= pend_s;
    end
  end

  // Frame buffer capture on an accepted fft_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) frame_r[i] <= '0;
    end else if (accept_s) begin
      for (int i = 0; i < 16; i++) frame_r[i] <= in_s[i];
    end
  end

  // Stage 1: square the selected bin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_r       <= '0;
      sq_valid_r <= 1'b0;
      sq_bin_r   <= 4'd0;
    end else begin
      sq_valid_r <= sq_en_s;
      if (sq_en_s) begin
        sq_r     <= mag_sq(frame_r[idx_r]);
        sq_bin_r <= idx_r;
      end
    end
  end

  // Stage 2: running maximum; bin 0 opens a new frame, strict > keeps the
  // lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maxv_r <= '0;
      maxi_r <= 4'd0;
    end else if (sq_valid_r && ((sq_bin_r == 4'd0) || (sq_r > maxv_r))) begin
      maxv_r <= sq_r;
      maxi_r <= sq_bin_r;
    end
  end

  // Registered outputs: result publication one cycle after the final compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_r     <= 1'b0;
      done_r    <= 1'b0;
      freq_r    <= 4'd0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      fin_r     <= (state_r == FLUSH);
      done_r    <= fin_r;
      busy_r    <= (state_s != IDLE);
      overrun_r <= drop_s;
      if (fin_r) begin
        freq_r <= maxi_r;
      end
    end
  end

  assign done    = done_r;
  assign freq    = freq_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_fft_peak_detect.sv
module tb_fft_peak_detect;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] fr  [16];
  logic [31:0] frb [16];
  logic        done;
  logic [3:0]  freq;
  logic        busy;
  logic        overrun;

  int checks;
  int failures;
  int done_cnt, done_c1, done_c2, freq1, freq2, busy_cnt, ovr_cnt, ovr_c;

  fft_peak_detect #(.DW(16), .MW(32)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fr[0]),   .fft_d1(fr[1]),   .fft_d2(fr[2]),   .fft_d3(fr[3]),
    .fft_d4(fr[4]),   .fft_d5(fr[5]),   .fft_d6(fr[6]),   .fft_d7(fr[7]),
    .fft_d8(fr[8]),   .fft_d9(fr[9]),   .fft_d10(fr[10]), .fft_d11(fr[11]),
    .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
    .done(done), .freq(freq), .busy(busy), .overrun(overrun)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 16; i++) begin
      fr[i]  = 32'h0;
      frb[i] = 32'h0;
    end
  endtask

  task automatic sample(input int c);
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) begin
        done_c1 = c;
        freq1   = int'(freq);
      end else begin
        done_c2 = c;
        freq2   = int'(freq);
      end
    end
    if (busy) busy_cnt++;
    if (overrun) begin
      ovr_cnt++;
      ovr_c = c;
    end
  endtask

  // Pulse fft_valid at edge E0 with frame fr, optionally swap in frb after E0,
  // optionally raise fft_valid again so it is sampled at edge E<second_at>,
  // and record what the outputs do for ncyc cycles (sample c is #1 after E_c).
  task automatic run_seq(input bit load_b, input int second_at, input int ncyc);
    done_cnt = 0; done_c1 = 0; done_c2 = 0; freq1 = 0; freq2 = 0;
    busy_cnt = 0; ovr_cnt = 0; ovr_c = 0;
    @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    if (load_b) begin
      for (int i = 0; i < 16; i++) fr[i] = frb[i];
    end
    sample(0);
    for (int c = 1; c <= ncyc; c++) begin
      fft_valid = (c == second_at);
      @(posedge clk);
      #1;
      fft_valid = 1'b0;
      sample(c);
    end
  endtask

  task automatic check_single(input string tag, input int exp_freq);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_latency"},  done_c1, 18);
    check_eq({tag, "_freq"},     freq1, exp_freq);
    check_eq({tag, "_busy_cyc"}, busy_cnt, 17);
    check_eq({tag, "_overrun"},  ovr_cnt, 0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    fft_valid = 1'b0;
    clear_frames();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", done, 0);
    check_eq("rst_freq", freq, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr",  overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: single peak at bin 5 (1024^2 + 768^2)
    clear_frames();
    fr[5] = {16'h0400, 16'h0300};
    run_seq(1'b0, 0, 24);
    check_single("t1", 5);

    // 2a: equal magnitudes 2^16 at bins 3 and 9, lowest index wins
    clear_frames();
    fr[3] = {16'h0100, 16'h0000};
    fr[9] = {16'h0000, 16'hFF00};
    run_seq(1'b0, 0, 24);
    check_single("t2_tie", 3);

    // 2b: all-zero frame
    clear_frames();
    run_seq(1'b0, 0, 24);
    check_single("t2_zero", 0);

    // 3a: -2^15 on both parts gives 2^31, above 2*(2^15-1)^2
    for (int i = 0; i < 16; i++) fr[i] = {16'h7FFF, 16'h7FFF};
    fr[12] = {16'h8000, 16'h8000};
    run_seq(1'b0, 0, 24);
    check_single("t3_extreme", 12);

    // 3b: -256 (65536) beats +255 (65025)
    clear_frames();
    fr[0] = {16'hFF00, 16'h0000};
    fr[1] = {16'h00FF, 16'h0000};
    run_seq(1'b0, 0, 24);
    check_single("t3_sign", 0);

    // 4: back-to-back frames 16 cycles apart, peaks 2 then 14
    clear_frames();
    fr[2]   = {16'h0010, 16'h0000};
    frb[14] = {16'h0000, 16'h0020};
    frb[2]  = {16'h0001, 16'h0000};
    run_seq(1'b1, 16, 40);
    check_eq("t4_done_cnt", done_cnt, 2);
    check_eq("t4_done1_at", done_c1, 18);
    check_eq("t4_done2_at", done_c2, 34);
    check_eq("t4_freq1",    freq1, 2);
    check_eq("t4_freq2",    freq2, 14);
    check_eq("t4_overrun",  ovr_cnt, 0);
    check_eq("t4_busy_cyc", busy_cnt, 33);

    // 5: second fft_valid 8 cycles later is dropped
    clear_frames();
    fr[7]  = {16'h0020, 16'h0000};
    frb[1] = {16'h4000, 16'h0000};
    run_seq(1'b1, 8, 30);
    check_eq("t5_overrun_cnt", ovr_cnt, 1);
    check_eq("t5_overrun_at",  ovr_c, 8);
    check_eq("t5_done_cnt",    done_cnt, 1);
    check_eq("t5_done_at",     done_c1, 18);
    check_eq("t5_freq",        freq1, 7);

    // 6: reset mid-scan at idx=7 abandons the frame
    clear_frames();
    fr[4] = {16'h0100, 16'h0000};
    @(negedge clk);
    fft_valid = 1'b1;
    @(posedge clk);
    #1;
    fft_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_freq", freq, 0);
    check_eq("t6_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0; ovr_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      sample(c);
    end
    check_eq("t6_no_done",   done_cnt, 0);
    check_eq("t6_idle_busy", busy_cnt, 0);
    check_eq("t6_idle_freq", freq, 0);
    clear_frames();
    fr[10] = {16'h0000, 16'h0123};
    fr[4]  = {16'h0001, 16'h0001};
    run_seq(1'b0, 0, 24);
    check_single("t6_after", 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
